// File: rtl/cndm_proto_pcie_us_axil_rq_if.sv
// Bus bundle for the AXI-lite to PCIe RQ/RC bridge: AXI-lite slave, RQ master and RC slave.
// The slave modport is the bridge's view; the master modport is the surrounding system's view.
interface cndm_proto_pcie_us_axil_rq_if #(
    parameter int unsigned AXIL_ADDR_W = 32
);
    logic [AXIL_ADDR_W-1:0] s_axil_awaddr;
    logic                   s_axil_awvalid;
    logic                   s_axil_awready;
    logic [31:0]            s_axil_wdata;
    logic [3:0]             s_axil_wstrb;
    logic                   s_axil_wvalid;
    logic                   s_axil_wready;
    logic [1:0]             s_axil_bresp;
    logic                   s_axil_bvalid;
    logic                   s_axil_bready;
    logic [AXIL_ADDR_W-1:0] s_axil_araddr;
    logic                   s_axil_arvalid;
    logic                   s_axil_arready;
    logic [31:0]            s_axil_rdata;
    logic [1:0]             s_axil_rresp;
    logic                   s_axil_rvalid;
    logic                   s_axil_rready;

    logic [255:0]           m_axis_rq_tdata;
    logic [7:0]             m_axis_rq_tkeep;
    logic [61:0]            m_axis_rq_tuser;
    logic                   m_axis_rq_tvalid;
    logic                   m_axis_rq_tready;
    logic                   m_axis_rq_tlast;

    logic [255:0]           s_axis_rc_tdata;
    logic [7:0]             s_axis_rc_tkeep;
    logic [74:0]            s_axis_rc_tuser;
    logic                   s_axis_rc_tvalid;
    logic                   s_axis_rc_tready;
    logic                   s_axis_rc_tlast;

    modport slave (
        input  s_axil_awaddr, s_axil_awvalid, s_axil_wdata, s_axil_wstrb, s_axil_wvalid,
        input  s_axil_bready, s_axil_araddr, s_axil_arvalid, s_axil_rready,
        output s_axil_awready, s_axil_wready, s_axil_bresp, s_axil_bvalid,
        output s_axil_arready, s_axil_rdata, s_axil_rresp, s_axil_rvalid,
        output m_axis_rq_tdata, m_axis_rq_tkeep, m_axis_rq_tuser, m_axis_rq_tvalid,
        output m_axis_rq_tlast,
        input  m_axis_rq_tready,
        input  s_axis_rc_tdata, s_axis_rc_tkeep, s_axis_rc_tuser, s_axis_rc_tvalid,
        input  s_axis_rc_tlast,
        output s_axis_rc_tready
    );

    modport master (
        output s_axil_awaddr, s_axil_awvalid, s_axil_wdata, s_axil_wstrb, s_axil_wvalid,
        output s_axil_bready, s_axil_araddr, s_axil_arvalid, s_axil_rready,
        input  s_axil_awready, s_axil_wready, s_axil_bresp, s_axil_bvalid,
        input  s_axil_arready, s_axil_rdata, s_axil_rresp, s_axil_rvalid,
        input  m_axis_rq_tdata, m_axis_rq_tkeep, m_axis_rq_tuser, m_axis_rq_tvalid,
        input  m_axis_rq_tlast,
        output m_axis_rq_tready,
        output s_axis_rc_tdata, s_axis_rc_tkeep, s_axis_rc_tuser, s_axis_rc_tvalid,
        output s_axis_rc_tlast,
        input  s_axis_rc_tready
    );
endinterface

// File: rtl/cndm_proto_pcie_us_axil_rq.sv
// Single-outstanding AXI-lite slave bridged to UltraScale PCIe RQ (1-DW MemWr/MemRd) with the
// read data returned from the matching RC completion.
module cndm_proto_pcie_us_axil_rq #(
    parameter int unsigned AXIL_ADDR_W = 32,
    parameter int unsigned TAG_W       = 5,
    parameter int unsigned TIMEOUT     = 65535
) (
    input  logic        clk,
    input  logic        rst_n,
    cndm_proto_pcie_us_axil_rq_if.slave bus,
    input  logic [63:0] pcie_base_addr,
    output logic        busy,
    output logic        stat_timeout
);
    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_WR_TLP  = 3'd1;
    localparam logic [2:0] ST_WR_RESP = 3'd2;
    localparam logic [2:0] ST_RD_TLP  = 3'd3;
    localparam logic [2:0] ST_RD_WAIT = 3'd4;
    localparam logic [2:0] ST_RD_RESP = 3'd5;

    logic [2:0]       r_state;
    logic             r_awready;
    logic             r_wready;
    logic             r_arready;
    logic             r_bvalid;
    logic             r_rvalid;
    logic [31:0]      r_rdata;
    logic [1:0]       r_rresp;
    logic [255:0]     r_rq_tdata;
    logic [7:0]       r_rq_tkeep;
    logic [61:0]      r_rq_tuser;
    logic             r_rq_tvalid;
    logic             r_rq_tlast;
    logic             r_rc_tready;
    logic [TAG_W-1:0] r_tag;
    logic [7:0]       r_issued_tag;
    logic [CNT_W-1:0] r_tmo_cnt;
    logic             r_rc_sop;
    logic             r_rc_match;
    logic             r_busy;
    logic             r_stat_timeout;

    logic [63:0]      w_wr_addr;
    logic [63:0]      w_rd_addr;
    logic [255:0]     w_wr_desc;
    logic [255:0]     w_rd_desc;
    logic             w_rc_beat;
    logic             w_rc_hit_first;
    logic             w_rc_claimed;
    logic             w_tmo_hit;
    logic             w_rc_ok;
    logic             w_unused;

    assign w_wr_addr = pcie_base_addr + 64'(bus.s_axil_awaddr);
    assign w_rd_addr = pcie_base_addr + 64'(bus.s_axil_araddr);

    always_comb begin
        w_wr_desc            = '0;
        w_wr_desc[63:2]      = w_wr_addr[63:2];
        w_wr_desc[74:64]     = 11'd1;
        w_wr_desc[78:75]     = 4'b0001;
        w_wr_desc[159:128]   = bus.s_axil_wdata;
        w_rd_desc            = '0;
        w_rd_desc[63:2]      = w_rd_addr[63:2];
        w_rd_desc[74:64]     = 11'd1;
        w_rd_desc[103:96]    = 8'(r_tag);
    end

    assign w_rc_beat      = bus.s_axis_rc_tvalid && r_rc_tready;
    assign w_rc_hit_first = w_rc_beat && r_rc_sop && (bus.s_axis_rc_tdata[71:64] == r_issued_tag);
    // Once a matching completion has started it owns the read; the timeout can no longer fire.
    assign w_rc_claimed   = w_rc_hit_first || r_rc_match;
    assign w_tmo_hit      = (r_tmo_cnt == CNT_W'(TIMEOUT - 1));
    assign w_rc_ok        = (bus.s_axis_rc_tdata[45:43] == 3'd0);

    assign w_unused = ^{bus.s_axis_rc_tkeep, bus.s_axis_rc_tuser, bus.s_axis_rc_tdata[255:128],
                        bus.s_axis_rc_tdata[95:72], bus.s_axis_rc_tdata[63:46],
                        bus.s_axis_rc_tdata[42:0], w_wr_addr[1:0], w_rd_addr[1:0]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= ST_IDLE;
            r_awready      <= 1'b0;
            r_wready       <= 1'b0;
            r_arready      <= 1'b0;
            r_bvalid       <= 1'b0;
            r_rvalid       <= 1'b0;
            r_rdata        <= '0;
            r_rresp        <= '0;
            r_rq_tdata     <= '0;
            r_rq_tkeep     <= '0;
            r_rq_tuser     <= '0;
            r_rq_tvalid    <= 1'b0;
            r_rq_tlast     <= 1'b0;
            r_rc_tready    <= 1'b0;
            r_tag          <= '0;
            r_issued_tag   <= '0;
            r_tmo_cnt      <= '0;
            r_rc_sop       <= 1'b1;
            r_rc_match     <= 1'b0;
            r_busy         <= 1'b0;
            r_stat_timeout <= 1'b0;
        end else begin
            r_stat_timeout <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    // Ready is raised one cycle ahead so the handshake cycle sees registered ready.
                    if (r_awready) begin
                        r_awready <= 1'b0;
                        r_wready  <= 1'b0;
                        if (bus.s_axil_awvalid && bus.s_axil_wvalid) begin
                            r_rq_tdata  <= w_wr_desc;
                            r_rq_tkeep  <= 8'h1F;
                            r_rq_tuser  <= {58'd0, bus.s_axil_wstrb};
                            r_rq_tvalid <= 1'b1;
                            r_rq_tlast  <= 1'b1;
                            r_busy      <= 1'b1;
                            r_state     <= ST_WR_TLP;
                        end
                    end else if (r_arready) begin
                        r_arready <= 1'b0;
                        if (bus.s_axil_arvalid) begin
                            r_rq_tdata   <= w_rd_desc;
                            r_rq_tkeep   <= 8'h0F;
                            r_rq_tuser   <= {58'd0, 4'hF};
                            r_rq_tvalid  <= 1'b1;
                            r_rq_tlast   <= 1'b1;
                            r_issued_tag <= 8'(r_tag);
                            r_busy       <= 1'b1;
                            r_state      <= ST_RD_TLP;
                        end
                    end else if (bus.s_axil_awvalid && bus.s_axil_wvalid) begin
                        r_awready <= 1'b1;
                        r_wready  <= 1'b1;
                    end else if (bus.s_axil_arvalid) begin
                        r_arready <= 1'b1;
                    end
                end
                ST_WR_TLP: begin
                    if (bus.m_axis_rq_tready) begin
                        r_rq_tvalid <= 1'b0;
                        r_rq_tlast  <= 1'b0;
                        r_bvalid    <= 1'b1;
                        r_state     <= ST_WR_RESP;
                    end
                end
                ST_WR_RESP: begin
                    if (bus.s_axil_bready) begin
                        r_bvalid <= 1'b0;
                        r_busy   <= 1'b0;
                        r_state  <= ST_IDLE;
                    end
                end
                ST_RD_TLP: begin
                    if (bus.m_axis_rq_tready) begin
                        r_rq_tvalid <= 1'b0;
                        r_rq_tlast  <= 1'b0;
                        r_tag       <= r_tag + 1'b1;
                        r_tmo_cnt   <= '0;
                        r_rc_tready <= 1'b1;
                        r_state     <= ST_RD_WAIT;
                    end
                end
                ST_RD_WAIT: begin
                    if (w_rc_beat) begin
                        // SOP tracking survives leaving RD_WAIT so a half-consumed TLP is finished later.
                        r_rc_sop <= bus.s_axis_rc_tlast;
                        if (w_rc_hit_first) begin
                            r_rdata    <= w_rc_ok ? bus.s_axis_rc_tdata[127:96] : 32'hFFFF_FFFF;
                            r_rresp    <= w_rc_ok ? 2'b00 : 2'b10;
                            r_rc_match <= !bus.s_axis_rc_tlast;
                        end else if (r_rc_match && bus.s_axis_rc_tlast) begin
                            r_rc_match <= 1'b0;
                        end
                        if ((w_rc_hit_first || r_rc_match) && bus.s_axis_rc_tlast) begin
                            r_rvalid    <= 1'b1;
                            r_rc_tready <= 1'b0;
                            r_state     <= ST_RD_RESP;
                        end
                    end
                    if (!w_rc_claimed && w_tmo_hit) begin
                        r_stat_timeout <= 1'b1;
                        r_rdata        <= 32'hFFFF_FFFF;
                        r_rresp        <= 2'b10;
                        r_rvalid       <= 1'b1;
                        r_rc_tready    <= 1'b0;
                        r_state        <= ST_RD_RESP;
                    end else if (!w_tmo_hit) begin
                        r_tmo_cnt <= r_tmo_cnt + 1'b1;
                    end
                end
                ST_RD_RESP: begin
                    if (bus.s_axil_rready) begin
                        r_rvalid <= 1'b0;
                        r_busy   <= 1'b0;
                        r_state  <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.s_axil_awready   = r_awready;
    assign bus.s_axil_wready    = r_wready;
    assign bus.s_axil_bresp     = 2'b00;
    assign bus.s_axil_bvalid    = r_bvalid;
    assign bus.s_axil_arready   = r_arready;
    assign bus.s_axil_rdata     = r_rdata;
    assign bus.s_axil_rresp     = r_rresp;
    assign bus.s_axil_rvalid    = r_rvalid;
    assign bus.m_axis_rq_tdata  = r_rq_tdata;
    assign bus.m_axis_rq_tkeep  = r_rq_tkeep;
    assign bus.m_axis_rq_tuser  = r_rq_tuser;
    assign bus.m_axis_rq_tvalid = r_rq_tvalid;
    assign bus.m_axis_rq_tlast  = r_rq_tlast;
    assign bus.s_axis_rc_tready = r_rc_tready;
    assign busy                 = r_busy;
    assign stat_timeout         = r_stat_timeout;
endmodule

// File: tb/tb_cndm_proto_pcie_us_axil_rq.sv
// Directed bench for the AXI-lite to PCIe RQ bridge; TIMEOUT shortened to 100 cycles.
module tb_cndm_proto_pcie_us_axil_rq;
    logic        clk;
    logic        rst_n;
    logic [63:0] pcie_base_addr;
    logic        busy;
    logic        stat_timeout;
    int          n_checks;
    int          n_fail;

    cndm_proto_pcie_us_axil_rq_if #(.AXIL_ADDR_W(32)) bus ();

    cndm_proto_pcie_us_axil_rq #(
        .AXIL_ADDR_W(32),
        .TAG_W      (5),
        .TIMEOUT    (100)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .bus           (bus),
        .pcie_base_addr(pcie_base_addr),
        .busy          (busy),
        .stat_timeout  (stat_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [255:0] rq_desc(input logic [63:0] addr, input logic wr,
                                             input logic [7:0] tag, input logic [31:0] data);
        logic [255:0] d;
        d          = '0;
        d[63:0]    = addr;
        d[74:64]   = 11'd1;
        d[78:75]   = {3'b000, wr};
        d[103:96]  = tag;
        if (wr) d[159:128] = data;
        return d;
    endfunction

    function automatic logic [255:0] rc_tlp(input logic [7:0] tag, input logic [2:0] status,
                                            input logic [31:0] data);
        logic [255:0] d;
        d         = '0;
        d[71:64]  = tag;
        d[45:43]  = status;
        d[127:96] = data;
        return d;
    endfunction

    task automatic wait_aw();
        for (int i = 0; i < 20 && bus.s_axil_awready !== 1'b1; i++) tick();
        chk("wait_awready", bus.s_axil_awready, 1'b1);
    endtask

    task automatic wait_ar();
        for (int i = 0; i < 20 && bus.s_axil_arready !== 1'b1; i++) tick();
        chk("wait_arready", bus.s_axil_arready, 1'b1);
    endtask

    task automatic wait_rc();
        for (int i = 0; i < 20 && bus.s_axis_rc_tready !== 1'b1; i++) tick();
        chk("wait_rc_tready", bus.s_axis_rc_tready, 1'b1);
    endtask

    task automatic do_write(input string tag, input logic [31:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, input logic [63:0] exp_addr);
        bus.s_axil_awaddr  = addr;
        bus.s_axil_wdata   = data;
        bus.s_axil_wstrb   = strb;
        bus.s_axil_awvalid = 1'b1;
        bus.s_axil_wvalid  = 1'b1;
        wait_aw();
        tick();
        bus.s_axil_awvalid = 1'b0;
        bus.s_axil_wvalid  = 1'b0;
        chk({tag, "_tvalid"}, bus.m_axis_rq_tvalid, 1'b1);
        chk({tag, "_tdata"}, bus.m_axis_rq_tdata, rq_desc(exp_addr, 1'b1, 8'd0, data));
        chk({tag, "_tkeep"}, bus.m_axis_rq_tkeep, 8'h1F);
        chk({tag, "_tuser"}, bus.m_axis_rq_tuser, {58'd0, strb});
        chk({tag, "_tlast"}, bus.m_axis_rq_tlast, 1'b1);
        chk({tag, "_busy"}, busy, 1'b1);
        bus.m_axis_rq_tready = 1'b1;
        tick();
        bus.m_axis_rq_tready = 1'b0;
        chk({tag, "_tvalid_drop"}, bus.m_axis_rq_tvalid, 1'b0);
        chk({tag, "_bvalid"}, bus.s_axil_bvalid, 1'b1);
        chk({tag, "_bresp"}, bus.s_axil_bresp, 2'b00);
        bus.s_axil_bready = 1'b1;
        tick();
        bus.s_axil_bready = 1'b0;
        chk({tag, "_bvalid_drop"}, bus.s_axil_bvalid, 1'b0);
        chk({tag, "_idle"}, busy, 1'b0);
    endtask

    task automatic start_read(input string tag, input logic [31:0] addr,
                              input logic [63:0] exp_addr, input logic [7:0] exp_tag);
        bus.s_axil_araddr  = addr;
        bus.s_axil_arvalid = 1'b1;
        wait_ar();
        tick();
        bus.s_axil_arvalid = 1'b0;
        chk({tag, "_tvalid"}, bus.m_axis_rq_tvalid, 1'b1);
        chk({tag, "_tdata"}, bus.m_axis_rq_tdata, rq_desc(exp_addr, 1'b0, exp_tag, 32'd0));
        chk({tag, "_tkeep"}, bus.m_axis_rq_tkeep, 8'h0F);
        chk({tag, "_tuser"}, bus.m_axis_rq_tuser, 62'hF);
        bus.m_axis_rq_tready = 1'b1;
        tick();
        bus.m_axis_rq_tready = 1'b0;
        chk({tag, "_rc_tready"}, bus.s_axis_rc_tready, 1'b1);
    endtask

    task automatic send_rc(input logic [7:0] tag, input logic [2:0] status,
                           input logic [31:0] data, input logic last);
        bus.s_axis_rc_tdata  = rc_tlp(tag, status, data);
        bus.s_axis_rc_tkeep  = 8'hFF;
        bus.s_axis_rc_tlast  = last;
        bus.s_axis_rc_tvalid = 1'b1;
        wait_rc();
        tick();
        bus.s_axis_rc_tvalid = 1'b0;
        bus.s_axis_rc_tlast  = 1'b0;
    endtask

    task automatic end_read(input string tag, input logic [31:0] exp_data,
                            input logic [1:0] exp_resp);
        chk({tag, "_rvalid"}, bus.s_axil_rvalid, 1'b1);
        chk({tag, "_rdata"}, bus.s_axil_rdata, exp_data);
        chk({tag, "_rresp"}, bus.s_axil_rresp, exp_resp);
        bus.s_axil_rready = 1'b1;
        tick();
        bus.s_axil_rready = 1'b0;
        chk({tag, "_rvalid_drop"}, bus.s_axil_rvalid, 1'b0);
        chk({tag, "_idle"}, busy, 1'b0);
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_awready"}, bus.s_axil_awready, 1'b0);
        chk({tag, "_wready"}, bus.s_axil_wready, 1'b0);
        chk({tag, "_arready"}, bus.s_axil_arready, 1'b0);
        chk({tag, "_bvalid"}, bus.s_axil_bvalid, 1'b0);
        chk({tag, "_rvalid"}, bus.s_axil_rvalid, 1'b0);
        chk({tag, "_rdata"}, bus.s_axil_rdata, 32'd0);
        chk({tag, "_rq_tvalid"}, bus.m_axis_rq_tvalid, 1'b0);
        chk({tag, "_rq_tdata"}, bus.m_axis_rq_tdata, 256'd0);
        chk({tag, "_rc_tready"}, bus.s_axis_rc_tready, 1'b0);
        chk({tag, "_busy"}, busy, 1'b0);
        chk({tag, "_stat_timeout"}, stat_timeout, 1'b0);
    endtask

    initial begin
        logic [255:0] held;
        n_checks             = 0;
        n_fail               = 0;
        rst_n                = 1'b0;
        pcie_base_addr       = 64'h0000_0001_0000_0000;
        bus.s_axil_awaddr    = '0;
        bus.s_axil_awvalid   = 1'b0;
        bus.s_axil_wdata     = '0;
        bus.s_axil_wstrb     = '0;
        bus.s_axil_wvalid    = 1'b0;
        bus.s_axil_bready    = 1'b0;
        bus.s_axil_araddr    = '0;
        bus.s_axil_arvalid   = 1'b0;
        bus.s_axil_rready    = 1'b0;
        bus.m_axis_rq_tready = 1'b0;
        bus.s_axis_rc_tdata  = '0;
        bus.s_axis_rc_tkeep  = '0;
        bus.s_axis_rc_tuser  = '0;
        bus.s_axis_rc_tvalid = 1'b0;
        bus.s_axis_rc_tlast  = 1'b0;
        tick();
        tick();
        chk_quiet("reset");
        rst_n = 1'b1;
        tick();

        // Basic write
        do_write("wr1", 32'h10, 32'hDEAD_BEEF, 4'hF, 64'h0000_0001_0000_0010);

        // Basic read, tag 0
        start_read("rd1", 32'h20, 64'h0000_0001_0000_0020, 8'd0);
        send_rc(8'd0, 3'd0, 32'h1234_5678, 1'b1);
        end_read("rd1", 32'h1234_5678, 2'b00);

        // Stale two-beat completion (second beat carries the live tag) is dropped
        start_read("rd2", 32'h24, 64'h0000_0001_0000_0024, 8'd1);
        send_rc(8'd5, 3'd0, 32'hAAAA_AAAA, 1'b0);
        send_rc(8'd1, 3'd0, 32'hBBBB_BBBB, 1'b1);
        chk("rd2_stale_dropped", bus.s_axil_rvalid, 1'b0);
        send_rc(8'd1, 3'd0, 32'h0BAD_F00D, 1'b1);
        end_read("rd2", 32'h0BAD_F00D, 2'b00);

        // Timeout after 100 cycles in RD_WAIT
        start_read("rd3", 32'h30, 64'h0000_0001_0000_0030, 8'd2);
        repeat (99) tick();
        chk("tmo_early_stat", stat_timeout, 1'b0);
        chk("tmo_early_rvalid", bus.s_axil_rvalid, 1'b0);
        tick();
        chk("tmo_stat", stat_timeout, 1'b1);
        tick();
        chk("tmo_stat_pulse", stat_timeout, 1'b0);
        end_read("rd3", 32'hFFFF_FFFF, 2'b10);

        // Late completion for the timed-out tag waits unconsumed, then is dropped
        bus.s_axis_rc_tdata  = rc_tlp(8'd2, 3'd0, 32'h5555_5555);
        bus.s_axis_rc_tlast  = 1'b1;
        bus.s_axis_rc_tvalid = 1'b1;
        tick();
        tick();
        chk("late_rc_held", bus.s_axis_rc_tready, 1'b0);
        bus.s_axis_rc_tvalid = 1'b0;
        bus.s_axis_rc_tlast  = 1'b0;
        start_read("rd4", 32'h34, 64'h0000_0001_0000_0034, 8'd3);
        send_rc(8'd2, 3'd0, 32'h5555_5555, 1'b1);
        chk("late_dropped", bus.s_axil_rvalid, 1'b0);
        send_rc(8'd3, 3'd0, 32'hCAFE_0003, 1'b1);
        end_read("rd4", 32'hCAFE_0003, 2'b00);

        // Completion with non-zero status
        start_read("rd5", 32'h38, 64'h0000_0001_0000_0038, 8'd4);
        send_rc(8'd4, 3'd1, 32'h1111_1111, 1'b1);
        end_read("rd5", 32'hFFFF_FFFF, 2'b10);

        // Write and read together: write first, RQ back-pressured 10 cycles
        bus.s_axil_awaddr  = 32'h40;
        bus.s_axil_wdata   = 32'hA5A5_0040;
        bus.s_axil_wstrb   = 4'h3;
        bus.s_axil_awvalid = 1'b1;
        bus.s_axil_wvalid  = 1'b1;
        bus.s_axil_araddr  = 32'h44;
        bus.s_axil_arvalid = 1'b1;
        wait_aw();
        chk("prio_no_arready", bus.s_axil_arready, 1'b0);
        tick();
        bus.s_axil_awvalid = 1'b0;
        bus.s_axil_wvalid  = 1'b0;
        held = rq_desc(64'h0000_0001_0000_0040, 1'b1, 8'd0, 32'hA5A5_0040);
        chk("prio_wr_tdata", bus.m_axis_rq_tdata, held);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("bp_tvalid", bus.m_axis_rq_tvalid, 1'b1);
            chk("bp_tdata", bus.m_axis_rq_tdata, held);
            chk("bp_no_accept", {bus.s_axil_awready, bus.s_axil_arready}, 2'b00);
        end
        bus.m_axis_rq_tready = 1'b1;
        tick();
        bus.m_axis_rq_tready = 1'b0;
        chk("prio_bvalid", bus.s_axil_bvalid, 1'b1);
        bus.s_axil_bready = 1'b1;
        tick();
        bus.s_axil_bready = 1'b0;
        start_read("rd6", 32'h44, 64'h0000_0001_0000_0044, 8'd5);
        send_rc(8'd5, 3'd0, 32'h0000_0044, 1'b1);
        end_read("rd6", 32'h0000_0044, 2'b00);

        // wstrb=0 still issues a TLP; address add wraps and drops bits [1:0]
        pcie_base_addr = 64'hFFFF_FFFF_FFFF_FFF0;
        do_write("wr_wrap", 32'h17, 32'h0000_0077, 4'h0, 64'h0000_0000_0000_0004);
        pcie_base_addr = 64'h0000_0001_0000_0000;

        // Reset while waiting for a completion
        start_read("rd7", 32'h50, 64'h0000_0001_0000_0050, 8'd6);
        rst_n = 1'b0;
        #1;
        chk_quiet("rst_rd_wait");
        tick();
        rst_n = 1'b1;
        tick();
        start_read("rd8", 32'h54, 64'h0000_0001_0000_0054, 8'd0);
        send_rc(8'd0, 3'd0, 32'h7654_3210, 1'b1);
        end_read("rd8", 32'h7654_3210, 2'b00);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
